// File: rtl/cpu_dma_rx_sched_if.sv
// DMA-source and CPU-queue signal bundle for the CPU DMA receive scheduler.
// The slave modport is the scheduler; the master modport is the DMA source plus queues.
interface cpu_dma_rx_sched_if #(
  parameter int unsigned NUM_QUEUES     = 4,
  parameter int unsigned QSEL_WIDTH     = 2,
  parameter int unsigned DMA_DATA_WIDTH = 32,
  parameter int unsigned DMA_CTRL_WIDTH = DMA_DATA_WIDTH / 8
);
  logic [NUM_QUEUES-1:0]     sched_en;
  logic [NUM_QUEUES-1:0]     dma_q_req;
  logic                      dma_grant;
  logic [QSEL_WIDTH-1:0]     dma_grant_q;
  logic                      dma_busy;
  logic                      dma_nearly_full;
  logic                      dma_wr;
  logic                      dma_wr_pkt_vld;
  logic [DMA_DATA_WIDTH-1:0] dma_wr_data;
  logic [DMA_CTRL_WIDTH-1:0] dma_wr_ctrl;
  logic                      dma_xfer_done;
  logic                      dma_xfer_abort;
  logic                      dma_wr_err;
  logic [NUM_QUEUES-1:0]     cpu_q_dma_can_wr_pkt;
  logic [NUM_QUEUES-1:0]     cpu_q_dma_nearly_full;
  logic [NUM_QUEUES-1:0]     cpu_q_dma_wr;
  logic                      cpu_q_dma_wr_pkt_vld;
  logic [DMA_DATA_WIDTH-1:0] cpu_q_dma_wr_data;
  logic [DMA_CTRL_WIDTH-1:0] cpu_q_dma_wr_ctrl;

  modport master (
    output sched_en, dma_q_req, dma_wr, dma_wr_pkt_vld, dma_wr_data, dma_wr_ctrl,
           cpu_q_dma_can_wr_pkt, cpu_q_dma_nearly_full,
    input  dma_grant, dma_grant_q, dma_busy, dma_nearly_full, dma_xfer_done,
           dma_xfer_abort, dma_wr_err, cpu_q_dma_wr, cpu_q_dma_wr_pkt_vld,
           cpu_q_dma_wr_data, cpu_q_dma_wr_ctrl
  );

  modport slave (
    input  sched_en, dma_q_req, dma_wr, dma_wr_pkt_vld, dma_wr_data, dma_wr_ctrl,
           cpu_q_dma_can_wr_pkt, cpu_q_dma_nearly_full,
    output dma_grant, dma_grant_q, dma_busy, dma_nearly_full, dma_xfer_done,
           dma_xfer_abort, dma_wr_err, cpu_q_dma_wr, cpu_q_dma_wr_pkt_vld,
           cpu_q_dma_wr_data, cpu_q_dma_wr_ctrl
  );
endinterface

// File: rtl/cpu_dma_rx_sched.sv
// Round-robin scheduler sharing one host DMA write channel among CPU receive queues.
// Steers each granted packet to its queue and closes stalled packets with an invalid word.
module cpu_dma_rx_sched #(
  parameter int unsigned NUM_QUEUES     = 4,
  parameter int unsigned QSEL_WIDTH     = 2,
  parameter int unsigned DMA_DATA_WIDTH = 32,
  parameter int unsigned DMA_CTRL_WIDTH = DMA_DATA_WIDTH / 8,
  parameter int unsigned TIMEOUT        = 1024,
  parameter int unsigned TO_WIDTH       = 11
) (
  input logic               clk,
  input logic               reset,
  cpu_dma_rx_sched_if.slave bus
);
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_FIRST, XFER} state_t;

  state_t                    state_r, state_nxt;
  logic [QSEL_WIDTH-1:0]     rr_r, rr_nxt;
  logic [QSEL_WIDTH-1:0]     grant_q_r, grant_q_nxt;
  logic [TO_WIDTH-1:0]       to_r, to_nxt;
  logic                      grant_r, grant_nxt;
  logic                      busy_r, busy_nxt;
  logic                      nf_r, nf_nxt;
  logic                      done_r, done_nxt;
  logic                      abort_r, abort_nxt;
  logic                      err_r, err_nxt;
  logic [NUM_QUEUES-1:0]     qwr_r, qwr_nxt;
  logic                      vld_r, vld_nxt;
  logic [DMA_DATA_WIDTH-1:0] data_r, data_nxt;
  logic [DMA_CTRL_WIDTH-1:0] ctrl_r, ctrl_nxt;

  logic [NUM_QUEUES-1:0]     eligible;
  logic                      pick_vld;
  logic [QSEL_WIDTH-1:0]     pick_idx;
  logic [QSEL_WIDTH-1:0]     rr_rel;
  logic [NUM_QUEUES-1:0]     sel_onehot;

  // Round-robin search starting at rr_r; only indices below NUM_QUEUES are visited.
  always_comb begin
    int unsigned cand;
    eligible = bus.dma_q_req & bus.cpu_q_dma_can_wr_pkt & bus.sched_en;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int unsigned i = 0; i < NUM_QUEUES; i++) begin
      cand = (32'(rr_r) + i) % NUM_QUEUES;
      if (!pick_vld && eligible[QSEL_WIDTH'(cand)]) begin
        pick_vld = 1'b1;
        pick_idx = QSEL_WIDTH'(cand);
      end
    end
  end

  assign rr_rel     = QSEL_WIDTH'((32'(grant_q_r) + 32'd1) % NUM_QUEUES);
  assign sel_onehot = NUM_QUEUES'(1) << grant_q_r;

  always_comb begin
    state_nxt   = state_r;
    rr_nxt      = rr_r;
    grant_q_nxt = grant_q_r;
    to_nxt      = to_r;
    grant_nxt   = 1'b0;
    busy_nxt    = busy_r;
    done_nxt    = 1'b0;
    abort_nxt   = 1'b0;
    err_nxt     = 1'b0;
    qwr_nxt     = '0;
    vld_nxt     = vld_r;
    data_nxt    = data_r;
    ctrl_nxt    = ctrl_r;
    nf_nxt      = busy_r ? bus.cpu_q_dma_nearly_full[grant_q_r] : 1'b1;

    case (state_r)
      IDLE: begin
        err_nxt = bus.dma_wr;
        if (pick_vld) begin
          state_nxt   = WAIT_FIRST;
          grant_nxt   = 1'b1;
          grant_q_nxt = pick_idx;
          busy_nxt    = 1'b1;
          to_nxt      = '0;
        end
      end
      WAIT_FIRST, XFER: begin
        if (bus.dma_wr) begin
          qwr_nxt  = sel_onehot;
          vld_nxt  = bus.dma_wr_pkt_vld;
          data_nxt = bus.dma_wr_data;
          ctrl_nxt = bus.dma_wr_ctrl;
          to_nxt   = '0;
          // The length word never terminates a packet, whatever its ctrl says.
          if (state_r == WAIT_FIRST) begin
            state_nxt = XFER;
          end else if (bus.dma_wr_ctrl != '0) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            rr_nxt    = rr_rel;
          end
        end else if (to_r == TO_LAST) begin
          state_nxt = IDLE;
          abort_nxt = 1'b1;
          busy_nxt  = 1'b0;
          rr_nxt    = rr_rel;
          to_nxt    = '0;
          if (state_r == XFER) begin
            qwr_nxt  = sel_onehot;
            vld_nxt  = 1'b0;
            data_nxt = '0;
            ctrl_nxt = DMA_CTRL_WIDTH'(1);
          end
        end else begin
          to_nxt = to_r + TO_WIDTH'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      rr_r      <= '0;
      grant_q_r <= '0;
      to_r      <= '0;
      grant_r   <= 1'b0;
      busy_r    <= 1'b0;
      nf_r      <= 1'b1;
      done_r    <= 1'b0;
      abort_r   <= 1'b0;
      err_r     <= 1'b0;
      qwr_r     <= '0;
      vld_r     <= 1'b0;
      data_r    <= '0;
      ctrl_r    <= '0;
    end else begin
      state_r   <= state_nxt;
      rr_r      <= rr_nxt;
      grant_q_r <= grant_q_nxt;
      to_r      <= to_nxt;
      grant_r   <= grant_nxt;
      busy_r    <= busy_nxt;
      nf_r      <= nf_nxt;
      done_r    <= done_nxt;
      abort_r   <= abort_nxt;
      err_r     <= err_nxt;
      qwr_r     <= qwr_nxt;
      vld_r     <= vld_nxt;
      data_r    <= data_nxt;
      ctrl_r    <= ctrl_nxt;
    end
  end

  assign bus.dma_grant            = grant_r;
  assign bus.dma_grant_q          = grant_q_r;
  assign bus.dma_busy             = busy_r;
  assign bus.dma_nearly_full      = nf_r;
  assign bus.dma_xfer_done        = done_r;
  assign bus.dma_xfer_abort       = abort_r;
  assign bus.dma_wr_err           = err_r;
  assign bus.cpu_q_dma_wr         = qwr_r;
  assign bus.cpu_q_dma_wr_pkt_vld = vld_r;
  assign bus.cpu_q_dma_wr_data    = data_r;
  assign bus.cpu_q_dma_wr_ctrl    = ctrl_r;
endmodule

// File: tb/tb_cpu_dma_rx_sched.sv
// Bench for cpu_dma_rx_sched: directed steps plus randomized packets against a
// transaction-level round-robin model and an expected-write queue.
module tb_cpu_dma_rx_sched;
  localparam int unsigned NQ  = 4;
  localparam int unsigned QW  = 2;
  localparam int unsigned DW  = 32;
  localparam int unsigned CW  = 4;
  localparam int unsigned TMO = 16;
  localparam int unsigned TOW = 5;

  typedef struct {
    logic [NQ-1:0] wr;
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic          v;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_mis = 0;
  int   n_grant = 0;
  int   ptr = 0;
  wr_t  exp_q[$];

  cpu_dma_rx_sched_if #(.NUM_QUEUES(NQ), .QSEL_WIDTH(QW), .DMA_DATA_WIDTH(DW),
                        .DMA_CTRL_WIDTH(CW)) bus ();

  cpu_dma_rx_sched #(.NUM_QUEUES(NQ), .QSEL_WIDTH(QW), .DMA_DATA_WIDTH(DW),
                     .DMA_CTRL_WIDTH(CW), .TIMEOUT(TMO), .TO_WIDTH(TOW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Round-robin reference: first eligible queue at or after ptr, wrapping.
  function automatic int pick(input logic [NQ-1:0] e);
    for (int i = 0; i < int'(NQ); i++) begin
      if (e[(ptr + i) % int'(NQ)]) return (ptr + i) % int'(NQ);
    end
    return -1;
  endfunction

  // Advance one clock and score any queue write against the expected stream.
  task automatic tick();
    wr_t e;
    @(posedge clk);
    #1;
    if (bus.dma_grant === 1'b1) n_grant++;
    if (bus.cpu_q_dma_wr !== '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wr", 64'(bus.cpu_q_dma_wr), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("wr_strobe", 64'(bus.cpu_q_dma_wr), 64'(e.wr));
        check("wr_data", 64'(bus.cpu_q_dma_wr_data), 64'(e.d));
        check("wr_ctrl", 64'(bus.cpu_q_dma_wr_ctrl), 64'(e.c));
        check("wr_pkt_vld", 64'(bus.cpu_q_dma_wr_pkt_vld), 64'(e.v));
      end
    end
  endtask

  task automatic do_reset();
    bus.dma_wr = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ptr = 0;
  endtask

  task automatic check_reset_outputs();
    check("rst_grant", 64'(bus.dma_grant), 64'(0));
    check("rst_grant_q", 64'(bus.dma_grant_q), 64'(0));
    check("rst_busy", 64'(bus.dma_busy), 64'(0));
    check("rst_nearly_full", 64'(bus.dma_nearly_full), 64'(1));
    check("rst_done", 64'(bus.dma_xfer_done), 64'(0));
    check("rst_abort", 64'(bus.dma_xfer_abort), 64'(0));
    check("rst_err", 64'(bus.dma_wr_err), 64'(0));
    check("rst_q_wr", 64'(bus.cpu_q_dma_wr), 64'(0));
    check("rst_q_data", 64'(bus.cpu_q_dma_wr_data), 64'(0));
    check("rst_q_ctrl", 64'(bus.cpu_q_dma_wr_ctrl), 64'(0));
    check("rst_q_vld", 64'(bus.cpu_q_dma_wr_pkt_vld), 64'(0));
  endtask

  task automatic wait_grant(input int exp, output int lat);
    bit seen = 1'b0;
    lat = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      lat++;
      seen = (bus.dma_grant === 1'b1);
    end
    check("grant_seen", 64'(seen), 64'(1));
    if (seen) begin
      check("grant_q", 64'(bus.dma_grant_q), 64'(exp));
      check("grant_busy", 64'(bus.dma_busy), 64'(1));
    end
  endtask

  task automatic send_word(input int q, input logic [DW-1:0] d, input logic [CW-1:0] c,
                           input logic v);
    wr_t e;
    e.wr = NQ'(1) << q;
    e.d  = d;
    e.c  = c;
    e.v  = v;
    exp_q.push_back(e);
    bus.dma_wr         = 1'b1;
    bus.dma_wr_data    = d;
    bus.dma_wr_ctrl    = c;
    bus.dma_wr_pkt_vld = v;
    tick();
    bus.dma_wr         = 1'b0;
    bus.dma_wr_data    = DW'($urandom);
    bus.dma_wr_ctrl    = CW'($urandom);
  endtask

  // Normal packet of n>=2 words; the length word carries random ctrl to prove it never ends a packet.
  task automatic send_pkt(input int q, input int n, input int gmax);
    logic [CW-1:0] c;
    for (int w = 0; w < n; w++) begin
      repeat ($urandom_range(0, gmax)) tick();
      if (w == n - 1)  c = CW'($urandom_range(1, (1 << CW) - 1));
      else if (w == 0) c = CW'($urandom);
      else             c = '0;
      send_word(q, DW'($urandom), c, 1'($urandom));
      if (w < n - 1) check("done_early", 64'(bus.dma_xfer_done), 64'(0));
    end
    check("done_pulse", 64'(bus.dma_xfer_done), 64'(1));
    check("busy_drop", 64'(bus.dma_busy), 64'(0));
    ptr = (q + 1) % int'(NQ);
  endtask

  // Stall after nwords words; expect abort exactly TMO cycles after the last activity.
  task automatic timeout_pkt(input int q, input int nwords);
    wr_t e;
    for (int w = 0; w < nwords; w++)
      send_word(q, DW'($urandom), (w == 0) ? CW'($urandom) : CW'(0), 1'($urandom));
    if (nwords > 0) begin
      e.wr = NQ'(1) << q;
      e.d  = '0;
      e.c  = CW'(1);
      e.v  = 1'b0;
      exp_q.push_back(e);
    end
    repeat (TMO - 1) tick();
    check("abort_early", 64'(bus.dma_xfer_abort), 64'(0));
    tick();
    check("abort_pulse", 64'(bus.dma_xfer_abort), 64'(1));
    check("abort_busy", 64'(bus.dma_busy), 64'(0));
    ptr = (q + 1) % int'(NQ);
  endtask

  logic [NQ-1:0] r_req, r_can, r_en;
  logic [QW-1:0] r_sel;
  int            lat, q, g0, mode;

  initial begin
    bus.sched_en              = '0;
    bus.dma_q_req             = '0;
    bus.cpu_q_dma_can_wr_pkt  = '0;
    bus.cpu_q_dma_nearly_full = '0;
    bus.dma_wr                = 1'b0;
    bus.dma_wr_pkt_vld        = 1'b0;
    bus.dma_wr_data           = '0;
    bus.dma_wr_ctrl           = '0;
    reset = 1'b1;
    tick();
    do_reset();
    check_reset_outputs();

    // Basic packet to q0, nearly_full lag, then q2 next.
    bus.sched_en = 4'hF; bus.cpu_q_dma_can_wr_pkt = 4'hF; bus.dma_q_req = 4'b0101;
    wait_grant(pick(4'b0101), lat);
    check("nf_lag_on_grant", 64'(bus.dma_nearly_full), 64'(1));
    send_word(0, DW'($urandom), 4'hF, 1'b1);
    check("len_not_last", 64'(bus.dma_xfer_done), 64'(0));
    check("nf_follows_q", 64'(bus.dma_nearly_full), 64'(0));
    send_word(0, DW'($urandom), 4'h0, 1'b1);
    send_word(0, DW'($urandom), 4'h2, 1'b1);
    check("done_3word", 64'(bus.dma_xfer_done), 64'(1));
    check("nf_lag_on_done", 64'(bus.dma_nearly_full), 64'(0));
    ptr = 1;
    wait_grant(pick(4'b0101), lat);
    check("nf_idle_high", 64'(bus.dma_nearly_full), 64'(1));
    send_pkt(2, 2, 0);

    // All requesting from reset: strict rotation, one idle cycle between grants.
    bus.dma_q_req = 4'hF;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      q = pick(4'hF);
      check("rr_order", 64'(q), 64'(i % 4));
      wait_grant(q, lat);
      check("grant_latency", 64'(lat), 64'(1));
      send_pkt(q, 2 + i % 3, 2);
    end

    // Queue without room is skipped until it can take a packet.
    bus.dma_q_req = 4'b0010; bus.cpu_q_dma_can_wr_pkt = 4'b1101;
    g0 = n_grant;
    repeat (10) tick();
    check("no_grant_full_q", 64'(n_grant - g0), 64'(0));
    bus.cpu_q_dma_can_wr_pkt = 4'hF;
    wait_grant(pick(4'b0010), lat);
    send_pkt(1, 3, 1);

    // Mid-packet stall on q3 gets an injected invalid terminator.
    bus.dma_q_req = 4'b1000;
    wait_grant(pick(4'b1000), lat);
    bus.dma_q_req = 4'b0011;
    timeout_pkt(3, 2);

    // Grant with no words: abort, nothing written, next requester served.
    wait_grant(pick(4'b0011), lat);
    timeout_pkt(0, 0);
    wait_grant(pick(4'b0011), lat);
    check("post_abort_q1", 64'(bus.dma_grant_q), 64'(1));
    send_pkt(1, 2, 0);

    // A word arriving on the expiry cycle wins over the timeout.
    bus.dma_q_req = 4'b0100;
    wait_grant(pick(4'b0100), lat);
    bus.dma_q_req = 4'b0000;
    send_word(2, DW'($urandom), 4'h0, 1'b1);
    repeat (TMO - 1) tick();
    send_word(2, DW'($urandom), 4'h1, 1'b1);
    check("expiry_wr_no_abort", 64'(bus.dma_xfer_abort), 64'(0));
    check("expiry_wr_done", 64'(bus.dma_xfer_done), 64'(1));
    ptr = 3;

    // Stray write while idle.
    tick();
    bus.dma_wr = 1'b1; bus.dma_wr_data = DW'($urandom); bus.dma_wr_ctrl = 4'h1;
    tick();
    bus.dma_wr = 1'b0;
    check("wr_err_pulse", 64'(bus.dma_wr_err), 64'(1));
    check("wr_err_no_fwd", 64'(bus.cpu_q_dma_wr), 64'(0));
    tick();
    check("wr_err_clear", 64'(bus.dma_wr_err), 64'(0));

    // Reset in the middle of a transfer.
    bus.dma_q_req = 4'b0001;
    wait_grant(pick(4'b0001), lat);
    send_word(0, DW'($urandom), 4'h3, 1'b1);
    send_word(0, DW'($urandom), 4'h0, 1'b1);
    bus.dma_q_req = 4'b0000;
    do_reset();
    check_reset_outputs();

    // Randomized arbitration and packet mix; grant is never revoked by input changes.
    for (int it = 0; it < 12; it++) begin
      r_en = NQ'($urandom); r_can = NQ'($urandom); r_req = NQ'($urandom);
      if ((r_req & r_can & r_en) == '0) begin
        r_sel = QW'($urandom);
        r_req[r_sel] = 1'b1; r_can[r_sel] = 1'b1; r_en[r_sel] = 1'b1;
      end
      bus.sched_en = r_en; bus.cpu_q_dma_can_wr_pkt = r_can; bus.dma_q_req = r_req;
      q = pick(r_req & r_can & r_en);
      wait_grant(q, lat);
      check("rand_latency", 64'(lat), 64'(1));
      bus.sched_en = NQ'($urandom); bus.cpu_q_dma_can_wr_pkt = NQ'($urandom);
      mode = int'($urandom_range(0, 3));
      case (mode)
        0, 1:    send_pkt(q, int'($urandom_range(2, 5)), 3);
        2:       timeout_pkt(q, int'($urandom_range(1, 3)));
        default: timeout_pkt(q, 0);
      endcase
    end

    bus.dma_q_req = '0;
    repeat (3) tick();
    check("exp_writes_drained", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
